// File: rtl/or_unit_arbiter.sv
// or_unit_arbiter: round-robin arbiter that shares one bitwise-OR datapath
// among N_REQ requesters. One transaction is in flight at a time. The
// IDLE -> EXEC -> RESP sequence gives three clocks minimum per transaction.
module or_unit_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int N_REQ      = 4,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  input  logic                        rsp_ready,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic [ID_W-1:0]       ptr_q,       ptr_d;
  logic [DATA_WIDTH-1:0] op_a_q,      op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q,      op_b_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q,    rsp_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q,      busy_d;

  logic                  found;
  logic [ID_W-1:0]       win_id;

  // Round-robin search: first valid requester starting at ptr and wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        found  = 1'b1;
        win_id = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // State and datapath registers; everything clears on reset, including ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath updates: accept in IDLE, OR in EXEC, hand off in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        // A winner always sees its own ready, so found means a transfer this edge.
        if (found) begin
          op_a_d   = req_a[win_id*DATA_WIDTH +: DATA_WIDTH];
          op_b_d   = req_b[win_id*DATA_WIDTH +: DATA_WIDTH];
          rsp_id_d = win_id;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = op_a_q | op_b_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Grant output: one-hot on the winner in IDLE only, forced low during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Bench for or_unit_arbiter: directed transactions push their hand-computed
// {id, data} into a scoreboard queue; a monitor pops and compares on every
// response handshake. Inputs change 1ns after posedge, outputs sampled on negedge.
module tb_or_unit_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0] req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_ready;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sb_q[$];

  or_unit_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready held high; starts and ends in IDLE.
  task automatic txn(input logic [3:0] vld, input logic [3:0] exp_grant,
                     input logic [1:0] exp_id, input logic [7:0] exp_data,
                     input logic [3:0] vld_after);
    req_valid = vld;
    sb_q.push_back({exp_id, exp_data});
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("grant", req_ready, exp_grant);
    step();
    req_valid = vld_after;
    @(negedge clk);
    check("exec_ready", req_ready, 0);
    check("exec_busy", busy, 1);
    check("exec_valid", rsp_valid, 0);
    step();
    @(negedge clk);
    check("resp_valid", rsp_valid, 1);
    check("resp_busy", busy, 1);
    step();
  endtask

  // Scoreboard monitor: a response handshake completes on the next posedge.
  always @(negedge clk) begin
    logic [9:0] exp;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", {22'd0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        exp = sb_q.pop_front();
        check("rsp_id", rsp_id, exp[9:8]);
        check("rsp_data", rsp_data, exp[7:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state, with requests present so the reset gating of req_ready is visible.
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    step();
    req_valid = '0;
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // Single requester: F0 | 0F.
    set_op(0, 8'hF0, 8'h0F);
    txn(4'b0001, 4'b0001, 2'd0, 8'hFF, 4'b0000);
    @(negedge clk);
    check("t1_busy_done", busy, 0);
    check("t1_valid_done", rsp_valid, 0);
    step();

    // Round-robin fairness from ptr 0 with all four requesting.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_op(i, 8'(1 << i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, 4'(1 << (k % 4)), 2'(k % 4), 8'(1 << (k % 4)),
          (k == 4) ? 4'b0000 : 4'b1111);
    end

    // Wrap and skip: ptr is 1; serve 2 -> ptr 3, then 0 wins by wrap, then 2.
    set_op(2, 8'h40, 8'h02);
    set_op(0, 8'h3C, 8'h03);
    txn(4'b0100, 4'b0100, 2'd2, 8'h42, 4'b0000);
    txn(4'b0101, 4'b0001, 2'd0, 8'h3F, 4'b0101);
    txn(4'b0101, 4'b0100, 2'd2, 8'h42, 4'b0000);

    // Backpressure on requester 3 (ptr 3); others keep requesting meanwhile.
    set_op(3, 8'hA0, 8'h05);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    sb_q.push_back({2'd3, 8'hA5});
    @(negedge clk);
    check("bp_grant", req_ready, 4'b1000);
    step();
    req_valid = 4'b1111;
    @(negedge clk);
    check("bp_exec_ready", req_ready, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 8'hA5);
      check("bp_id", rsp_id, 3);
      check("bp_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    step();
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", rsp_valid, 0);
    step();

    // Operand change after accept; ptr wrapped to 0 so requester 1 beats 3.
    set_op(1, 8'h10, 8'h01);
    set_op(3, 8'h77, 8'h77);
    req_valid = 4'b1010;
    sb_q.push_back({2'd1, 8'h11});
    @(negedge clk);
    check("chg_grant", req_ready, 4'b0010);
    step();
    set_op(1, 8'hFF, 8'hFF);
    req_valid = 4'b0000;
    step();
    @(negedge clk);
    check("chg_valid", rsp_valid, 1);
    step();

    // ptr is 2: requester 0 wins by wrap, leaving ptr 1.
    set_op(0, 8'h81, 8'h18);
    txn(4'b0001, 4'b0001, 2'd0, 8'h99, 4'b0000);

    // Reset mid-operation in RESP; the response is discarded.
    set_op(1, 8'h55, 8'hAA);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    check("rm_grant", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    step();
    @(negedge clk);
    check("rm_resp_valid", rsp_valid, 1);
    #2;
    req_valid = 4'b0011;
    rst_n     = 1'b0;
    #1;
    check("rm_valid", rsp_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_ready", req_ready, 0);
    check("rm_data", rsp_data, 0);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    // ptr must be back at 0, so requester 0 wins over 1.
    txn(4'b0011, 4'b0001, 2'd0, 8'h99, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or_unit_arbiter.md
# or_unit_arbiter

Round-robin arbiter and sequencer that shares a single DATA_WIDTH-bit bitwise-OR datapath among N_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, registers its operands, computes a | b, and returns the result tagged with the requester index over a valid/ready response channel. It sits between the requester blocks and the shared OR datapath; the OR itself is computed internally.

## Interface
- DATA_WIDTH, 8, operand/result width in bits (>=1)
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ), width of requester index (derived, not overridden)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  bit i: requester i offers an operand pair
- req_a  in  N_REQ*DATA_WIDTH  operand a of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  N_REQ*DATA_WIDTH  operand b, same packing as req_a
- req_ready  out  N_REQ  one-hot or zero; bit i: requester i accepted this cycle
- rsp_valid  out  1  result valid
- rsp_data  out  DATA_WIDTH  registered a | b
- rsp_id  out  ID_W  index of requester that owns rsp_data
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: winner = first i with req_valid[i] set, searching ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1. req_ready[winner] = 1 combinationally, all other bits 0. If no req_valid bit is set, req_ready = 0 and state stays IDLE.
- Transfer with requester i: req_valid[i] & req_ready[i] at a rising edge. On that edge, capture req_a/req_b slice i into op_a/op_b, capture i into rsp_id, and go to EXEC.
- EXEC: one cycle. rsp_data <= op_a | op_b, rsp_valid <= 1, go to RESP.
- RESP: hold rsp_data, rsp_id and rsp_valid stable until rsp_valid & rsp_ready. On that edge: rsp_valid <= 0, ptr <= (rsp_id + 1) mod N_REQ, go to IDLE.
- req_ready = 0 in EXEC and RESP. Only one transaction is in flight at a time.
- ptr wrap-around: rsp_id = N_REQ-1 gives ptr = 0.
- Requester dropping req_valid in IDLE before a transfer edge is legal. The winner is then re-evaluated combinationally.
- Changes to req_a/req_b after the transfer edge do not affect the result.
- rsp_ready is ignored outside RESP.
- Reset values: state IDLE, ptr 0, op_a/op_b 0, rsp_data 0, rsp_id 0, rsp_valid 0, busy 0. req_ready is forced to 0 while rst_n is low.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and ptr returns to 0.

## Timing
- Latency: transfer edge at cycle t gives rsp_valid high after the edge at t+1 (visible during cycle t+2 window, i.e., two edges after acceptance counting the transfer edge).
- Minimum cycle time per transaction is 3 clocks (IDLE, EXEC, RESP with rsp_ready already high).
- req_ready is a combinational function of state, ptr and req_valid. There is no combinational path from rsp_ready to req_ready.
- All outputs except req_ready are registered.
- rst_n asserts asynchronously, clearing state immediately. Deassertion is synchronous to clk by upstream convention.

## Test plan
- Single requester: rst_n released, req_valid=4'b0001, a=8'hF0, b=8'h0F, rsp_ready=1. Required: req_ready=4'b0001 for one cycle, then rsp_valid=1 two edges later with rsp_data=8'hFF and rsp_id=0; busy high for 2 cycles.
- Round-robin fairness: req_valid=4'b1111 held, each requester i with a=8'h01<<i, b=8'h00, rsp_ready=1. Required: grant order 0,1,2,3,0; rsp_data sequence 01,02,04,08,01; one result every 3 cycles.
- Wrap and skip: ptr=3 after serving requester 2, req_valid=4'b0101. Required: requester 0 granted next (wrap), then requester 2.
- Backpressure: result a=8'hA0, b=8'h05, rsp_ready=0 for 5 cycles. Required: rsp_valid, rsp_data=8'hA5 and rsp_id held stable, and req_ready=0 throughout. rsp_ready=1 completes the transfer and returns the FSM to IDLE.
- Operand change after accept: requester 1 accepted with a=8'h10, b=8'h01, then req_a changed to 8'hFF next cycle. Required: rsp_data=8'h11.
- Reset mid-operation: rst_n pulled low in RESP. Required: rsp_valid=0, busy=0 and req_ready=0 immediately; after release ptr=0 and requester 0 wins when req_valid=4'b0011.
